// File: rtl/axo32_alu_rv32im_pkg.sv
// Shared RV32IM opcode/funct encodings and the base integer ALU helper
// used by both the OP and OP-IMM paths of the ALU.
package axo32_alu_rv32im_pkg;

   localparam logic [6:0] RV_OP_LUI    = 7'b0110111;
   localparam logic [6:0] RV_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] RV_OP_JAL    = 7'b1101111;
   localparam logic [6:0] RV_OP_JALR   = 7'b1100111;
   localparam logic [6:0] RV_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] RV_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] RV_OP_STORE  = 7'b0100011;
   localparam logic [6:0] RV_OP_IMM    = 7'b0010011;
   localparam logic [6:0] RV_OP_OP     = 7'b0110011;

   localparam logic [6:0] RV_F7_BASE   = 7'b0000000;
   localparam logic [6:0] RV_F7_ALT    = 7'b0100000;
   localparam logic [6:0] RV_F7_MULDIV = 7'b0000001;

   localparam logic [2:0] RV_F3_ADD  = 3'd0;
   localparam logic [2:0] RV_F3_SLL  = 3'd1;
   localparam logic [2:0] RV_F3_SLT  = 3'd2;
   localparam logic [2:0] RV_F3_SLTU = 3'd3;
   localparam logic [2:0] RV_F3_XOR  = 3'd4;
   localparam logic [2:0] RV_F3_SR   = 3'd5;
   localparam logic [2:0] RV_F3_OR   = 3'd6;
   localparam logic [2:0] RV_F3_AND  = 3'd7;

   localparam logic [2:0] RV_F3_MUL    = 3'd0;
   localparam logic [2:0] RV_F3_MULH   = 3'd1;
   localparam logic [2:0] RV_F3_MULHSU = 3'd2;
   localparam logic [2:0] RV_F3_MULHU  = 3'd3;
   localparam logic [2:0] RV_F3_DIV    = 3'd4;
   localparam logic [2:0] RV_F3_DIVU   = 3'd5;
   localparam logic [2:0] RV_F3_REM    = 3'd6;
   localparam logic [2:0] RV_F3_REMU   = 3'd7;

   localparam logic [2:0] RV_F3_BEQ  = 3'd0;
   localparam logic [2:0] RV_F3_BNE  = 3'd1;
   localparam logic [2:0] RV_F3_BLT  = 3'd4;
   localparam logic [2:0] RV_F3_BGE  = 3'd5;
   localparam logic [2:0] RV_F3_BLTU = 3'd6;
   localparam logic [2:0] RV_F3_BGEU = 3'd7;

   // alt selects SUB for funct3 0 and SRA for funct3 5.
   function automatic logic [31:0] alu_base(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = 32'd0;
      case (f3)
         RV_F3_ADD:  r = alt ? a - b : a + b;
         RV_F3_SLL:  r = a << b[4:0];
         RV_F3_SLT:  r = {31'd0, $signed(a) < $signed(b)};
         RV_F3_SLTU: r = {31'd0, a < b};
         RV_F3_XOR:  r = a ^ b;
         RV_F3_SR:   r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         RV_F3_OR:   r = a | b;
         RV_F3_AND:  r = a & b;
         default:    r = 32'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/axo32_alu_rv32im_muldiv.sv
// Combinational RV32M multiply/divide unit; funct3 selects the operation.
module axo32_muldiv
   import axo32_alu_rv32im_pkg::*;
(
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [63:0] prod_ss, prod_su, prod_uu;
   logic [31:0] abs_l, abs_r, quo_s, rem_s, quo_u, rem_u;
   logic        rhs_zero, neg_q;

   // Modulo-2^64 products of sign/zero-extended operands give the right high halves.
   assign prod_ss = {{32{lhs[31]}}, lhs} * {{32{rhs[31]}}, rhs};
   assign prod_su = {{32{lhs[31]}}, lhs} * {32'd0, rhs};
   assign prod_uu = {32'd0, lhs} * {32'd0, rhs};

   assign rhs_zero = (rhs == 32'd0);
   assign abs_l    = lhs[31] ? 32'd0 - lhs : lhs;
   assign abs_r    = rhs[31] ? 32'd0 - rhs : rhs;
   assign neg_q    = lhs[31] ^ rhs[31];
   assign quo_u    = rhs_zero ? 32'hFFFF_FFFF : lhs / rhs;
   assign rem_u    = rhs_zero ? lhs : lhs % rhs;

   // Magnitude division handles the 0x8000_0000 / -1 overflow case without special casing.
   always_comb begin
      quo_s = 32'hFFFF_FFFF;
      rem_s = lhs;
      if (!rhs_zero) begin
         quo_s = abs_l / abs_r;
         rem_s = abs_l % abs_r;
         if (neg_q)   quo_s = 32'd0 - quo_s;
         if (lhs[31]) rem_s = 32'd0 - rem_s;
      end
   end

   always_comb begin
      result = 32'd0;
      case (funct3)
         RV_F3_MUL:    result = prod_ss[31:0];
         RV_F3_MULH:   result = prod_ss[63:32];
         RV_F3_MULHSU: result = prod_su[63:32];
         RV_F3_MULHU:  result = prod_uu[63:32];
         RV_F3_DIV:    result = quo_s;
         RV_F3_DIVU:   result = quo_u;
         RV_F3_REM:    result = rem_s;
         RV_F3_REMU:   result = rem_u;
         default:      result = 32'd0;
      endcase
   end

endmodule

// File: rtl/axo32_alu_rv32im.sv
// Stateless RV32IM execute ALU: decodes the raw instruction word and produces
// the result combinationally; clk and rst are present only for integration.
module axo32_alu_rv32im
   import axo32_alu_rv32im_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   input  logic [31:0] insn,
   output logic [31:0] res
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] md_res, imm_i, imm_s, upper;
   logic        br_eq, br_lt, br_ltu;
   logic        unused_ok;

   assign opcode = insn[6:0];
   assign funct3 = insn[14:12];
   assign funct7 = insn[31:25];
   assign imm_i  = {{20{insn[31]}}, insn[31:20]};
   assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign upper  = {rhs[19:0], 12'h000};
   assign br_eq  = (lhs == rhs);
   assign br_lt  = ($signed(lhs) < $signed(rhs));
   assign br_ltu = (lhs < rhs);
   assign unused_ok = &{1'b0, clk, rst, insn[19:15]};

   axo32_muldiv u_muldiv (
      .lhs    (lhs),
      .rhs    (rhs),
      .funct3 (funct3),
      .result (md_res)
   );

   always_comb begin
      res = 32'd0;
      case (opcode)
         RV_OP_OP: begin
            if (funct7 == RV_F7_BASE)
               res = alu_base(funct3, 1'b0, lhs, rhs);
            else if (funct7 == RV_F7_MULDIV)
               res = md_res;
            else if (funct7 == RV_F7_ALT && (funct3 == RV_F3_ADD || funct3 == RV_F3_SR))
               res = alu_base(funct3, 1'b1, lhs, rhs);
         end
         // Immediate bits occupy the funct7 field, so only insn[30] on shifts matters.
         RV_OP_IMM:   res = alu_base(funct3, (funct3 == RV_F3_SR) && insn[30], lhs, rhs);
         RV_OP_LUI:   res = upper;
         RV_OP_AUIPC: res = lhs + upper;
         RV_OP_JAL,
         RV_OP_JALR:  res = lhs + rhs;
         RV_OP_LOAD:  res = lhs + imm_i;
         RV_OP_STORE: res = lhs + imm_s;
         RV_OP_BRANCH: begin
            case (funct3)
               RV_F3_BEQ:  res = {31'd0, br_eq};
               RV_F3_BNE:  res = {31'd0, !br_eq};
               RV_F3_BLT:  res = {31'd0, br_lt};
               RV_F3_BGE:  res = {31'd0, !br_lt};
               RV_F3_BLTU: res = {31'd0, br_ltu};
               RV_F3_BGEU: res = {31'd0, !br_ltu};
               default:    res = 32'd0;
            endcase
         end
         default: res = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_axo32_alu_rv32im.sv
// Directed-vector bench for axo32_alu_rv32im with hand-computed expectations.
module tb_axo32_alu_rv32im;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lhs = 32'd0;
   logic [31:0] rhs = 32'd0;
   logic [31:0] insn = 32'd0;
   logic [31:0] res;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [6:0] OP   = 7'b0110011;
   localparam logic [6:0] OPI  = 7'b0010011;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] AUI  = 7'b0010111;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] ST   = 7'b0100011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] SYS  = 7'b1110011;

   axo32_alu_rv32im dut (
      .clk  (clk),
      .rst  (rst),
      .lhs  (lhs),
      .rhs  (rhs),
      .res  (res),
      .insn (insn)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] op);
      return {f7, 10'd0, f3, 5'd0, op};
   endfunction

   task automatic step(input string tag, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk);
      insn = i;
      lhs  = a;
      rhs  = b;
      #1;
      n_cmp++;
      assert (res === exp) else begin
         n_bad++;
         $error("FAIL %s: res=%h expected %h", tag, res, exp);
      end
      $display("%-8s insn=%h lhs=%h rhs=%h res=%h exp=%h", tag, i, a, b, res, exp);
   endtask

   initial begin
      // Result must be valid while reset is asserted.
      step("add_rst", enc(7'h00, 3'd0, OP), 32'hFFFF_FFFF, 32'd1, 32'd0);
      step("sub_rst", enc(7'h20, 3'd0, OP), 32'd0, 32'd1, 32'hFFFF_FFFF);
      @(negedge clk);
      rst = 1'b0;
      step("srl",     enc(7'h00, 3'd5, OP), 32'h8000_0000, 32'h21, 32'h4000_0000);
      step("sra",     enc(7'h20, 3'd5, OP), 32'h8000_0000, 32'h21, 32'hC000_0000);
      step("sll",     enc(7'h00, 3'd1, OP), 32'h8000_0000, 32'h21, 32'd0);
      step("slt",     enc(7'h00, 3'd2, OP), 32'hFFFF_FFFF, 32'd0, 32'd1);
      step("sltu",    enc(7'h00, 3'd3, OP), 32'hFFFF_FFFF, 32'd0, 32'd0);
      step("xor",     enc(7'h00, 3'd4, OP), 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
      step("or",      enc(7'h00, 3'd6, OP), 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
      step("and",     enc(7'h00, 3'd7, OP), 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234);
      step("mul",     enc(7'h01, 3'd0, OP), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      step("mulh",    enc(7'h01, 3'd1, OP), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      step("mulhsu",  enc(7'h01, 3'd2, OP), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      step("mulhu",   enc(7'h01, 3'd3, OP), 32'hFFFF_FFFF, 32'd2, 32'd1);
      step("div",     enc(7'h01, 3'd4, OP), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      step("rem",     enc(7'h01, 3'd6, OP), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      step("divu",    enc(7'h01, 3'd5, OP), 32'd7, 32'd2, 32'd3);
      step("remu",    enc(7'h01, 3'd7, OP), 32'd7, 32'd2, 32'd1);
      step("divu_z",  enc(7'h01, 3'd5, OP), 32'd123, 32'd0, 32'hFFFF_FFFF);
      step("div_z",   enc(7'h01, 3'd4, OP), 32'd5, 32'd0, 32'hFFFF_FFFF);
      step("rem_z",   enc(7'h01, 3'd6, OP), 32'd5, 32'd0, 32'd5);
      step("remu_z",  enc(7'h01, 3'd7, OP), 32'd9, 32'd0, 32'd9);
      step("div_ov",  enc(7'h01, 3'd4, OP), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      step("rem_ov",  enc(7'h01, 3'd6, OP), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      step("addi30",  enc(7'h20, 3'd0, OPI), 32'd5, 32'd3, 32'd8);
      step("srai",    enc(7'h20, 3'd5, OPI), 32'h8000_0000, 32'h401, 32'hC000_0000);
      step("srli",    enc(7'h00, 3'd5, OPI), 32'h8000_0000, 32'h001, 32'h4000_0000);
      step("lui",     enc(7'h00, 3'd0, LUI), 32'hDEAD_BEEF, 32'h0001_2345, 32'h1234_5000);
      step("auipc",   enc(7'h00, 3'd0, AUI), 32'h4000_0000, 32'h0001_2345, 32'h5234_5000);
      step("jal",     enc(7'h00, 3'd0, JAL), 32'h4000_0010, 32'd4, 32'h4000_0014);
      step("lw",      {12'hFFC, 5'd0, 3'd2, 5'd0, LD}, 32'h100, 32'd0, 32'hFC);
      step("sw",      {7'd0, 5'd0, 5'd0, 3'd2, 5'd8, ST}, 32'h100, 32'd0, 32'h108);
      step("blt",     enc(7'h00, 3'd4, BR), 32'hFFFF_FFFF, 32'd0, 32'd1);
      step("bltu",    enc(7'h00, 3'd6, BR), 32'hFFFF_FFFF, 32'd0, 32'd0);
      step("bge",     enc(7'h00, 3'd5, BR), 32'hFFFF_FFFF, 32'd0, 32'd0);
      step("beq",     enc(7'h00, 3'd0, BR), 32'd77, 32'd77, 32'd1);
      step("br_f3_2", enc(7'h00, 3'd2, BR), 32'd77, 32'd77, 32'd0);
      step("system",  enc(7'h00, 3'd0, SYS), 32'd1, 32'd2, 32'd0);
      step("bad_f7",  enc(7'h02, 3'd0, OP), 32'd1, 32'd2, 32'd0);
      step("sub_f7x", enc(7'h20, 3'd4, OP), 32'd1, 32'd2, 32'd0);
      // Reasserting reset must not disturb the combinational result.
      @(negedge clk);
      rst = 1'b1;
      step("mul_rst", enc(7'h01, 3'd0, OP), 32'd6, 32'd7, 32'd42);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axo32_alu_rv32im.md
AXO32_ALU_RV32IM -- requirements
Module: axo32_alu_rv32im

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; no internal state uses it.
REQ-002 SHALL have port rst, input, 1 bit: reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have port lhs, input, 32 bits: left operand (rs1 value, or PC for AUIPC/JAL/JALR).
REQ-004 SHALL have port rhs, input, 32 bits: right operand (rs2 value; sign-extended I-immediate for OP-IMM; insn[31:12] in bits 19:0 for LUI/AUIPC; link increment 4 or 2 for JAL/JALR).
REQ-005 SHALL have port res, output, 32 bits: result.
REQ-006 SHALL have port insn, input, 32 bits: raw RV32 instruction word; selects the operation.

Function
REQ-007 res SHALL be purely combinational from lhs, rhs and insn; zero latency; no handshake.
REQ-008 Decode SHALL use opcode insn[6:0], funct3 insn[14:12], funct7 insn[31:25].
REQ-009 OP with funct7 0000000, by funct3 0..7: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
REQ-010 OP with funct7 0100000: funct3 0 gives SUB (lhs-rhs); funct3 5 gives SRA.
REQ-011 OP with funct7 0000001, by funct3 0..7: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- MUL returns the low 32 bits; MULH* return the high 32 bits of the 64-bit product.
- MULHSU treats lhs as signed and rhs as unsigned.
REQ-012 OP-IMM SHALL follow REQ-009, with two exceptions: funct3 0 is always ADD; funct3 5 with insn[30]=1 is SRA.
REQ-013 All shifts SHALL use rhs[4:0] only.
REQ-014 SLT/SLTU SHALL return 32'd1 or 32'd0.
REQ-015 Division by zero:
- DIV and DIVU SHALL return 32'hFFFF_FFFF.
- REM and REMU SHALL return lhs.
REQ-016 Signed overflow (lhs=32'h8000_0000, rhs=32'hFFFF_FFFF): DIV SHALL return 32'h8000_0000 and REM SHALL return 0.
REQ-017 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-018 LUI: res SHALL equal {rhs[19:0],12'h000}.
REQ-019 AUIPC: res SHALL equal lhs + {rhs[19:0],12'h000}.
REQ-020 JAL/JALR: res SHALL equal lhs + rhs (link address).
REQ-021 LOAD: res SHALL equal lhs + sign-extended insn[31:20].
REQ-022 STORE: res SHALL equal lhs + sign-extended {insn[31:25],insn[11:7]}.
REQ-023 BRANCH: res SHALL be 32'd1 if the condition holds, else 32'd0.
- funct3 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
- funct3 2 and 3 SHALL return 0.
REQ-024 All additions SHALL wrap modulo 2^32.
REQ-025 Any other opcode (SYSTEM, MISC-MEM, undefined) and any unlisted funct7 SHALL return 32'd0.

Reset
REQ-026 The block SHALL hold no state; rst SHALL NOT affect res, and res SHALL be valid during reset.

Structure
REQ-027 Opcode, funct3 and funct7 constants SHALL come from the shared RV defines (RV_OP_* etc.) and SHALL NOT be redefined locally.
REQ-028 The multiply/divide unit SHALL be one combinational sub-module, axo32_muldiv (inputs lhs, rhs, funct3; output 32-bit result).

Verification
REQ-029 ADD/SUB wrap: OP ADD with lhs=32'hFFFF_FFFF, rhs=1 -> res=0; SUB with lhs=0, rhs=1 -> res=32'hFFFF_FFFF.
REQ-030 Shifts: lhs=32'h8000_0000, rhs=32'h21. SRL -> 32'h4000_0000; SRA -> 32'hC000_0000; SLL -> 0.
REQ-031 Multiply: lhs=32'hFFFF_FFFF, rhs=2.
- MUL -> 32'hFFFF_FFFE.
- MULH -> 32'hFFFF_FFFF.
- MULHU -> 1.
- MULHSU -> 32'hFFFF_FFFF.
REQ-032 Divide:
- DIV -7/2 -> 32'hFFFF_FFFD; REM -> 32'hFFFF_FFFF.
- DIVU x/0 -> 32'hFFFF_FFFF.
- REM 5/0 -> 5.
- DIV 32'h8000_0000 by -1 -> 32'h8000_0000.
REQ-033 Upper/link:
- LUI with rhs=32'h0001_2345 -> 32'h1234_5000.
- AUIPC with lhs=32'h4000_0000, same rhs -> 32'h5234_5000.
- JAL with lhs=32'h4000_0010, rhs=4 -> 32'h4000_0014.
REQ-034 Memory and branch:
- LW with insn[31:20]=12'hFFC, lhs=32'h100 -> 32'hFC.
- SW with offset 8, lhs=32'h100 -> 32'h108.
- BLT with lhs=-1, rhs=0 -> 1; BLTU with the same operands -> 0.
